// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit over a word-wide sync-read memory; `LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses
module load_store_unit #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic [WORD_LEN-1:0] addr_d,
    input  logic [WORD_LEN-1:0] rdata,
    output logic                wen,
    output logic [WORD_LEN-1:0] wdata
);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t state, state_n;

    logic                we_q, we_n;
    logic [2:0]          f3_q, f3_n;
    logic [1:0]          off_q, off_n;
    logic [15:0]         sdata_q, sdata_n;
    logic                resp_valid_n, resp_err_n;
    logic [WORD_LEN-1:0] resp_rdata_n, addr_d_n, wdata_n;

    logic                req_err;
    logic [1:0]          req_off;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [WORD_LEN-1:0] load_ext, merged;

    assign req_ready = (state == IDLE);
    assign wen       = (state == WR);

    // Request decode: error detection and the effective (possibly aligned) lane offset.
    always_comb begin
        if (req_we) begin
            req_err = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            req_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            req_err = 1'b1;
        end
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            req_err = 1'b1;
        end
`endif
        // Without trapping, misaligned halfword/word accesses fall back to the aligned lane.
        case (req_funct3[1:0])
            2'b01:   req_off = {req_addr[1], 1'b0};
            2'b10:   req_off = 2'b00;
            default: req_off = req_addr[1:0];
        endcase
    end

    // Lane extraction, extension and read-modify-write merge from the returned word.
    always_comb begin
        case (off_q)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = off_q[1] ? rdata[31:16] : rdata[15:0];

        case (f3_q[1:0])
            2'b00:   load_ext = f3_q[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_ext = f3_q[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = rdata;
        endcase

        merged = rdata;
        if (f3_q[1:0] == 2'b00) begin
            case (off_q)
                2'd0:    merged[7:0]   = sdata_q[7:0];
                2'd1:    merged[15:8]  = sdata_q[7:0];
                2'd2:    merged[23:16] = sdata_q[7:0];
                default: merged[31:24] = sdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = sdata_q;
        end else begin
            merged[15:0] = sdata_q;
        end
    end

    always_comb begin
        state_n      = state;
        we_n         = we_q;
        f3_n         = f3_q;
        off_n        = off_q;
        sdata_n      = sdata_q;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
        addr_d_n     = addr_d;
        wdata_n      = wdata;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    we_n     = req_we;
                    f3_n     = req_funct3;
                    off_n    = req_off;
                    sdata_n  = req_wdata[15:0];
                    addr_d_n = {req_addr[WORD_LEN-1:2], 2'b00};
                    if (req_err) begin
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else if (req_we && req_funct3[1:0] == 2'b10) begin
                        wdata_n = req_wdata;
                        state_n = WR;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD: begin
                state_n = CAP;
            end
            CAP: begin
                if (we_q) begin
                    wdata_n = merged;
                    state_n = WR;
                end else begin
                    resp_rdata_n = load_ext;
                    resp_valid_n = 1'b1;
                    state_n      = IDLE;
                end
            end
            WR: begin
                resp_valid_n = 1'b1;
                state_n      = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            sdata_q    <= 16'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            addr_d     <= '0;
            wdata      <= '0;
        end else begin
            state      <= state_n;
            we_q       <= we_n;
            f3_q       <= f3_n;
            off_q      <= off_n;
            sdata_q    <= sdata_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            addr_d     <= addr_d_n;
            wdata      <= wdata_n;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table-driven bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] addr_d;
    logic [31:0] rdata;
    logic        wen;
    logic [31:0] wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mem [0:63];

    load_store_unit #(.WORD_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .addr_d(addr_d), .rdata(rdata), .wen(wen), .wdata(wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wen) mem[addr_d[7:2]] <= wdata;
        rdata <= mem[addr_d[7:2]];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wen;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] er, input logic e,
                                input int lat, input int wn);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wd = d;
        v.exp_rdata = er; v.exp_err = e; v.exp_lat = lat; v.exp_wen = wn;
        return v;
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int lat, output int wn);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99; wn = 0; rd = 32'hx; er = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (wen) wn++;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, wn, cyc, r1c, r2c, lw_acc;
        logic [31:0] r1d, r2d;
        logic        r1e, pend;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[16] = 32'h8899AABB;

        vecs[0]  = mk(0, 3'b010, 32'h40, 0, 32'h8899AABB, 0, 3, 0);
        vecs[1]  = mk(0, 3'b000, 32'h41, 0, 32'hFFFFFFAA, 0, 3, 0);
        vecs[2]  = mk(0, 3'b100, 32'h43, 0, 32'h00000088, 0, 3, 0);
        vecs[3]  = mk(0, 3'b101, 32'h42, 0, 32'h00008899, 0, 3, 0);
        vecs[4]  = mk(0, 3'b001, 32'h42, 0, 32'hFFFF8899, 0, 3, 0);
        vecs[5]  = mk(1, 3'b000, 32'h42, 32'h123456CC, 32'h0, 0, 4, 1);
        vecs[6]  = mk(0, 3'b010, 32'h40, 0, 32'h88CCAABB, 0, 3, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[7]  = mk(1, 3'b001, 32'h43, 32'h0000BEEF, 32'h0, 1, 1, 0);
        vecs[8]  = mk(0, 3'b010, 32'h40, 0, 32'h88CCAABB, 0, 3, 0);
        vecs[9]  = mk(0, 3'b001, 32'h41, 0, 32'h0, 1, 1, 0);
        vecs[10] = mk(0, 3'b010, 32'h43, 0, 32'h0, 1, 1, 0);
`else
        vecs[7]  = mk(1, 3'b001, 32'h43, 32'h0000BEEF, 32'h0, 0, 4, 1);
        vecs[8]  = mk(0, 3'b010, 32'h40, 0, 32'hBEEFAABB, 0, 3, 0);
        vecs[9]  = mk(0, 3'b001, 32'h41, 0, 32'hFFFFAABB, 0, 3, 0);
        vecs[10] = mk(0, 3'b010, 32'h43, 0, 32'hBEEFAABB, 0, 3, 0);
`endif
        vecs[11] = mk(1, 3'b011, 32'h40, 32'hFFFFFFFF, 32'h0, 1, 1, 0);
        vecs[12] = mk(0, 3'b110, 32'h40, 0, 32'h0, 1, 1, 0);
        vecs[13] = mk(0, 3'b101, 32'h40, 0, 32'h0000AABB, 0, 3, 0);

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_addr_d", addr_d, 32'd0);
        check("rst_wen", {31'd0, wen}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er, lat, wn);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_wen_pulses", i), wn, vecs[i].exp_wen);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        check("mem_0x40_final", mem[16], 32'h88CCAABB);
`else
        check("mem_0x40_final", mem[16], 32'hBEEFAABB);
`endif

        // Back-to-back: LW held on the bus while the SW is in flight, accepted with the SW response.
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h44; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_we = 1'b0; req_wdata = 32'h0;
        cyc = 0; r1c = 0; r2c = 0; lw_acc = 0; r1d = 32'hx; r2d = 32'hx; r1e = 1'bx;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            cyc++;
            pend = 1'b0;
            if (resp_valid) begin
                if (r1c == 0) begin r1c = cyc; r1d = resp_rdata; r1e = resp_err; end
                else if (r2c == 0) begin r2c = cyc; r2d = resp_rdata; end
            end
            if (req_ready && req_valid && lw_acc == 0) begin
                lw_acc = cyc; pend = 1'b1;
            end
            @(posedge clk);
            #1 if (pend) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("b2b_sw_resp_cycle", r1c, 2);
        check("b2b_sw_resp_rdata", r1d, 32'h0);
        check("b2b_sw_resp_err", {31'd0, r1e}, 32'd0);
        check("b2b_lw_accept_cycle", lw_acc, 2);
        check("b2b_lw_resp_cycle", r2c, 5);
        check("b2b_lw_resp_rdata", r2d, 32'hDEADBEEF);

        // Reset while an SB sits in CAP: the store must never reach memory.
        @(negedge clk);
        mem[18] = 32'h11223344;
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h49; req_wdata = 32'h000000EE; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wn = 0;
        @(negedge clk);
        if (wen) wn++;
        @(negedge clk);
        if (wen) wn++;
        rst = 1'b1;
        @(negedge clk);
        if (wen) wn++;
        check("rstcap_req_ready", {31'd0, req_ready}, 32'd1);
        check("rstcap_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstcap_addr_d", addr_d, 32'd0);
        check("rstcap_wdata", wdata, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wen) wn++;
        end
        check("rstcap_req_ready_after", {31'd0, req_ready}, 32'd1);
        check("rstcap_wen_pulses", wn, 0);
        check("rstcap_mem_unchanged", mem[18], 32'h11223344);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
